// File: rtl/pipe_ctrl_if.sv
// Bundle of pipeline control signals between the datapath and pipe_ctrl.
// Combinational pass-through; no latency of its own.
// No backpressure: the controller expresses hold-off through stall/fetch_en.
interface pipe_ctrl_if #(
   parameter int CNT_W = 16
);
   // D1 operand description
   logic             d1_src0_en;
   logic [3:0]       d1_src0;
   logic             d1_src1_en;
   logic [3:0]       d1_src1;
   logic             d1_dst_en;
   logic [3:0]       d1_dst;
   // E resolution
   logic             e_redirect;
   logic [15:0]      e_target;
   logic             e_halt;
   // controller outputs
   logic [15:0]      pc;
   logic             fetch_en;
   logic [6:0]       stage_valid;
   logic             stall;
   logic             flush;
   logic             halted;
   logic [CNT_W-1:0] stall_cnt;
   logic [CNT_W-1:0] flush_cnt;

   // Datapath side: supplies operand/resolution info, consumes control.
   modport master (
      output d1_src0_en, d1_src0, d1_src1_en, d1_src1, d1_dst_en, d1_dst,
      output e_redirect, e_target, e_halt,
      input  pc, fetch_en, stage_valid, stall, flush, halted, stall_cnt, flush_cnt
   );

   // Controller side.
   modport slave (
      input  d1_src0_en, d1_src0, d1_src1_en, d1_src1, d1_dst_en, d1_dst,
      input  e_redirect, e_target, e_halt,
      output pc, fetch_en, stage_valid, stall, flush, halted, stall_cnt, flush_cnt
   );
endinterface

// File: rtl/pipe_ctrl.sv
// Sequencer for the 7-stage F1/F2/D1/D2/M1/M2/E pipe: PC, stage valids, RAW scoreboard, flush/halt.
// pc/stage_valid/halted/counters registered; stall, flush, fetch_en combinational from current state.
// Stall holds F1..D1 and injects a bubble into D2; redirect beats stall; halt beats both and is sticky.
module pipe_ctrl #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          CNT_W    = 16
) (
   input logic        i_clk,
   input logic        i_reset,
   pipe_ctrl_if.slave bus
);

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } state_t;

   // Scoreboard slot numbering: 0 = D2, 1 = M1, 2 = M2, 3 = E.
   localparam int SB_N = 4;

   state_t           r_state;
   state_t           w_state_nxt;

   logic [15:0]      r_pc;
   logic [6:0]       r_stage_valid;
   logic [SB_N-1:0]  r_sb_wen;
   logic [3:0]       r_sb_idx [SB_N];
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   logic [15:0]      w_pc_nxt;
   logic [6:0]       w_stage_valid_nxt;
   logic [SB_N-1:0]  w_sb_wen_nxt;
   logic [3:0]       w_sb_idx_nxt [SB_N];

   logic             w_halted;
   logic             w_src0_hit;
   logic             w_src1_hit;
   logic             w_hazard;
   logic             w_take_halt;
   logic             w_take_redir;
   logic             w_stall;
   logic             w_fetch_en;
   logic [15:0]      w_redir_pc;
   logic             w_stall_cnt_inc;
   logic             w_flush_cnt_inc;

   // Compare D1 sources against every in-flight writer; register 0 is hard-wired and never a dependency.
   always_comb begin
      w_src0_hit = 1'b0;
      w_src1_hit = 1'b0;
      for (int i = 0; i < SB_N; i++) begin
         if (r_sb_wen[i] && (r_sb_idx[i] == bus.d1_src0)) begin
            w_src0_hit = 1'b1;
         end
         if (r_sb_wen[i] && (r_sb_idx[i] == bus.d1_src1)) begin
            w_src1_hit = 1'b1;
         end
      end
      w_hazard = r_stage_valid[2] &
                 ((bus.d1_src0_en & (bus.d1_src0 != 4'd0) & w_src0_hit) |
                  (bus.d1_src1_en & (bus.d1_src1 != 4'd0) & w_src1_hit));
   end

   // Event priority: halt > redirect > stall > normal advance; nothing is taken once halted.
   always_comb begin
      w_take_halt  = r_stage_valid[6] & bus.e_halt & ~w_halted;
      w_take_redir = r_stage_valid[6] & bus.e_redirect & ~bus.e_halt & ~w_halted;
      w_stall      = w_hazard & ~w_take_redir & ~w_take_halt & ~w_halted;
      w_fetch_en   = ~w_halted & ~w_stall & ~w_take_halt;
      // Jump targets are halfword aligned; bit 0 of the target is dropped.
      w_redir_pc   = bus.e_target & 16'hFFFE;
   end

   // Run/halt state register.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state <= ST_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Run/halt next state: only a valid halt in E leaves RUN, only reset leaves HALT.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_RUN:  if (w_take_halt) w_state_nxt = ST_HALT;
         ST_HALT: w_state_nxt = ST_HALT;
         default: w_state_nxt = ST_RUN;
      endcase
   end

   // Run/halt output decode.
   always_comb begin
      w_halted = (r_state == ST_HALT);
   end

   // Next PC, stage valids and scoreboard for each of the four cycle kinds.
   always_comb begin
      w_pc_nxt          = r_pc;
      w_stage_valid_nxt = r_stage_valid;
      w_sb_wen_nxt      = r_sb_wen;
      w_sb_idx_nxt      = r_sb_idx;
      if (!w_halted) begin
         if (w_take_halt) begin
            // PC holds so the halting context stays visible.
            w_stage_valid_nxt = 7'd0;
            w_sb_wen_nxt      = '0;
         end else if (w_take_redir) begin
            // Everything younger than E is squashed, and E itself retires, so the pipe empties.
            w_pc_nxt          = w_redir_pc;
            w_stage_valid_nxt = 7'd0;
            w_sb_wen_nxt      = '0;
         end else if (w_stall) begin
            // F1..D1 freeze, a bubble drops into D2, D2..M2 drain forward.
            w_stage_valid_nxt = {r_stage_valid[5:3], 1'b0, r_stage_valid[2:0]};
            w_sb_wen_nxt      = {r_sb_wen[SB_N-2:0], 1'b0};
            for (int i = SB_N - 1; i > 0; i--) begin
               w_sb_idx_nxt[i] = r_sb_idx[i-1];
            end
            w_sb_idx_nxt[0]   = 4'd0;
         end else begin
            // Normal advance; a bubble in D1 becomes a non-writing D2 entry.
            w_pc_nxt          = r_pc + 16'd2;
            w_stage_valid_nxt = {r_stage_valid[5:0], 1'b1};
            w_sb_wen_nxt      = {r_sb_wen[SB_N-2:0], bus.d1_dst_en & r_stage_valid[2]};
            for (int i = SB_N - 1; i > 0; i--) begin
               w_sb_idx_nxt[i] = r_sb_idx[i-1];
            end
            w_sb_idx_nxt[0]   = bus.d1_dst;
         end
      end
   end

   // Pipeline state registers; reset discards all in-flight work.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_pc          <= RESET_PC;
         r_stage_valid <= 7'd0;
         r_sb_wen      <= '0;
         for (int i = 0; i < SB_N; i++) begin
            r_sb_idx[i] <= 4'd0;
         end
      end else begin
         r_pc          <= w_pc_nxt;
         r_stage_valid <= w_stage_valid_nxt;
         r_sb_wen      <= w_sb_wen_nxt;
         for (int i = 0; i < SB_N; i++) begin
            r_sb_idx[i] <= w_sb_idx_nxt[i];
         end
      end
   end

   // Counter increment enables; each counter sticks at all-ones.
   always_comb begin
      w_stall_cnt_inc = w_stall & (r_stall_cnt != {CNT_W{1'b1}});
      w_flush_cnt_inc = w_take_redir & (r_flush_cnt != {CNT_W{1'b1}});
   end

   // Saturating stall / flush performance counters.
   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall_cnt_inc) begin
            r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
         if (w_flush_cnt_inc) begin
            r_flush_cnt <= r_flush_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
         end
      end
   end

   assign bus.pc          = r_pc;
   assign bus.fetch_en    = w_fetch_en;
   assign bus.stage_valid = r_stage_valid;
   assign bus.stall       = w_stall;
   assign bus.flush       = w_take_redir;
   assign bus.halted      = w_halted;
   assign bus.stall_cnt   = r_stall_cnt;
   assign bus.flush_cnt   = r_flush_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: slot-array reference model checked every cycle, plus directed literals.
// Checks sampled on the falling edge; inputs change 1 time unit after the rising edge.
// Counters use an 8-bit width so saturation is reachable in a few hundred cycles.
module tb_pipe_ctrl;

   localparam int           CNT_W    = 8;
   localparam int           CMAX     = (1 << CNT_W) - 1;
   localparam logic [15:0]  RESET_PC = 16'h0000;

   logic clk = 1'b0;
   logic reset;

   pipe_ctrl_if #(.CNT_W(CNT_W)) bus ();

   pipe_ctrl #(.RESET_PC(RESET_PC), .CNT_W(CNT_W)) dut (
      .i_clk  (clk),
      .i_reset(reset),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   // One pipeline slot as the model sees it: is an instruction here, and which register it writes.
   typedef struct packed {
      bit       v;
      bit       wen;
      bit [3:0] idx;
   } slot_t;

   slot_t     m_pipe [7];
   slot_t     n_pipe [7];
   bit [15:0] m_pc, n_pc;
   bit        m_halt, n_halt;
   int        m_sc, n_sc, m_fc, n_fc;
   bit        armed;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.d1_src0_en = 1'b0; bus.d1_src0 = 4'd0;
      bus.d1_src1_en = 1'b0; bus.d1_src1 = 4'd0;
      bus.d1_dst_en  = 1'b0; bus.d1_dst  = 4'd0;
      bus.e_redirect = 1'b0; bus.e_target = 16'd0; bus.e_halt = 1'b0;
   endtask

   function automatic int sat_inc(input int v);
      return (v >= CMAX) ? CMAX : v + 1;
   endfunction

   // Reference model: derive this cycle's expected outputs, compare, then compute the next model state.
   always @(negedge clk) begin : cmp
      logic [6:0] sv;
      bit hz, th, tr, st;
      sv = 7'd0;
      hz = 1'b0;
      for (int s = 0; s < 7; s++) sv[s] = m_pipe[s].v;
      if (m_pipe[2].v) begin
         for (int s = 3; s < 7; s++) begin
            if (m_pipe[s].wen) begin
               if (bus.d1_src0_en && bus.d1_src0 != 4'd0 && bus.d1_src0 == m_pipe[s].idx) hz = 1'b1;
               if (bus.d1_src1_en && bus.d1_src1 != 4'd0 && bus.d1_src1 == m_pipe[s].idx) hz = 1'b1;
            end
         end
      end
      th = m_pipe[6].v && bus.e_halt && !m_halt;
      tr = m_pipe[6].v && bus.e_redirect && !bus.e_halt && !m_halt;
      st = hz && !tr && !th && !m_halt;

      if (armed) begin
         chk("m_pc",          32'(bus.pc),          32'(m_pc));
         chk("m_stage_valid", 32'(bus.stage_valid), 32'(sv));
         chk("m_stall",       32'(bus.stall),       32'(st));
         chk("m_flush",       32'(bus.flush),       32'(tr));
         chk("m_fetch_en",    32'(bus.fetch_en),    32'(!m_halt && !st && !th));
         chk("m_halted",      32'(bus.halted),      32'(m_halt));
         chk("m_stall_cnt",   32'(bus.stall_cnt),   32'(m_sc));
         chk("m_flush_cnt",   32'(bus.flush_cnt),   32'(m_fc));
      end

      n_pipe = m_pipe; n_pc = m_pc; n_halt = m_halt; n_sc = m_sc; n_fc = m_fc;
      if (reset) begin
         for (int s = 0; s < 7; s++) n_pipe[s] = '0;
         n_pc = RESET_PC; n_halt = 1'b0; n_sc = 0; n_fc = 0;
      end else if (m_halt) begin
         n_halt = 1'b1;
      end else if (th) begin
         for (int s = 0; s < 7; s++) n_pipe[s] = '0;
         n_halt = 1'b1;
      end else if (tr) begin
         for (int s = 0; s < 7; s++) n_pipe[s] = '0;
         n_pc = bus.e_target & 16'hFFFE;
         n_fc = sat_inc(m_fc);
      end else if (st) begin
         n_pipe[6] = m_pipe[5];
         n_pipe[5] = m_pipe[4];
         n_pipe[4] = m_pipe[3];
         n_pipe[3] = '0;
         n_sc = sat_inc(m_sc);
      end else begin
         for (int s = 6; s >= 4; s--) n_pipe[s] = m_pipe[s-1];
         n_pipe[3].v   = m_pipe[2].v;
         n_pipe[3].wen = m_pipe[2].v & bus.d1_dst_en;
         n_pipe[3].idx = bus.d1_dst;
         n_pipe[2] = m_pipe[1];
         n_pipe[1] = m_pipe[0];
         n_pipe[0].v = 1'b1; n_pipe[0].wen = 1'b0; n_pipe[0].idx = 4'd0;
         n_pc = m_pc + 16'd2;
      end
   end

   always @(posedge clk) begin
      m_pipe = n_pipe; m_pc = n_pc; m_halt = n_halt; m_sc = n_sc; m_fc = n_fc;
      if (reset) armed = 1'b1;
   end

   initial begin
      bit [15:0] h_pc;
      clear_inputs();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;

      // Free run from reset: pc 0,2,4,6,8 and valids filling from F1.
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("run_pc", 32'(bus.pc), 32'(2 * k));
         chk("run_sv", 32'(bus.stage_valid), 32'((1 << k) - 1));
         chk("run_fetch", 32'(bus.fetch_en), 32'd1);
         tick();
      end

      // RAW on r3: writer enters D2, reader in D1 stalls four cycles.
      bus.d1_dst_en = 1'b1; bus.d1_dst = 4'd3;
      tick();
      bus.d1_dst_en = 1'b0; bus.d1_src0_en = 1'b1; bus.d1_src0 = 4'd3;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk("raw_stall", 32'(bus.stall), 32'd1);
         chk("raw_pc", 32'(bus.pc), 32'h000C);
         if (k > 0) chk("raw_bubble", 32'(bus.stage_valid[3]), 32'd0);
         tick();
      end
      @(negedge clk);
      chk("raw_release", 32'(bus.stall), 32'd0);
      chk("raw_cnt", 32'(bus.stall_cnt), 32'd4);
      bus.d1_src0_en = 1'b0;
      tick();
      @(negedge clk);
      chk("raw_adv_pc", 32'(bus.pc), 32'h000E);

      // r0 never hazards.
      bus.d1_dst_en = 1'b1; bus.d1_dst = 4'd0;
      tick();
      bus.d1_dst_en = 1'b0;
      bus.d1_src0_en = 1'b1; bus.d1_src0 = 4'd0;
      bus.d1_src1_en = 1'b1; bus.d1_src1 = 4'd0;
      @(negedge clk);
      chk("r0_stall", 32'(bus.stall), 32'd0);
      clear_inputs();
      tick();

      // Redirect from a full pipe.
      repeat (7) tick();
      bus.e_redirect = 1'b1; bus.e_target = 16'h0041;
      @(negedge clk);
      chk("redir_full", 32'(bus.stage_valid), 32'h7F);
      chk("redir_flush", 32'(bus.flush), 32'd1);
      tick();
      clear_inputs();
      @(negedge clk);
      chk("redir_pc", 32'(bus.pc), 32'h0040);
      chk("redir_sv", 32'(bus.stage_valid), 32'd0);
      chk("redir_cnt", 32'(bus.flush_cnt), 32'd1);
      tick();
      @(negedge clk);
      chk("redir_refill", 32'(bus.stage_valid), 32'd1);
      chk("redir_pc2", 32'(bus.pc), 32'h0042);
      tick();

      // Redirect and hazard together: redirect wins.
      repeat (7) tick();
      bus.d1_dst_en = 1'b1; bus.d1_dst = 4'd5;
      tick();
      bus.d1_dst_en = 1'b0; bus.d1_src0_en = 1'b1; bus.d1_src0 = 4'd5;
      bus.e_redirect = 1'b1; bus.e_target = 16'h0100;
      @(negedge clk);
      chk("rh_stall", 32'(bus.stall), 32'd0);
      chk("rh_flush", 32'(bus.flush), 32'd1);
      tick();
      clear_inputs();
      @(negedge clk);
      chk("rh_scnt", 32'(bus.stall_cnt), 32'd4);
      chk("rh_fcnt", 32'(bus.flush_cnt), 32'd2);
      chk("rh_pc", 32'(bus.pc), 32'h0100);
      tick();

      // PC wrap from 0xFFFE.
      repeat (7) tick();
      bus.e_redirect = 1'b1; bus.e_target = 16'hFFFF;
      tick();
      clear_inputs();
      @(negedge clk);
      chk("wrap_pc0", 32'(bus.pc), 32'hFFFE);
      tick();
      @(negedge clk);
      chk("wrap_pc1", 32'(bus.pc), 32'h0000);
      chk("wrap_fcnt", 32'(bus.flush_cnt), 32'd3);
      tick();

      // Halt beats redirect; sticky until reset.
      repeat (7) tick();
      h_pc = m_pc;
      bus.e_halt = 1'b1; bus.e_redirect = 1'b1; bus.e_target = 16'h1234;
      @(negedge clk);
      chk("halt_fetch0", 32'(bus.fetch_en), 32'd0);
      chk("halt_flush0", 32'(bus.flush), 32'd0);
      tick();
      for (int k = 0; k < 10; k++) begin
         bus.e_halt = 1'($urandom_range(0, 1));
         bus.e_redirect = 1'($urandom_range(0, 1));
         bus.e_target = 16'($urandom);
         bus.d1_src0_en = 1'b1; bus.d1_src0 = 4'($urandom_range(1, 15));
         @(negedge clk);
         chk("halt_state", 32'(bus.halted), 32'd1);
         chk("halt_sv", 32'(bus.stage_valid), 32'd0);
         chk("halt_fetch", 32'(bus.fetch_en), 32'd0);
         chk("halt_pc", 32'(bus.pc), 32'(h_pc));
         tick();
      end
      clear_inputs();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      @(negedge clk);
      chk("rst_pc", 32'(bus.pc), 32'(RESET_PC));
      chk("rst_halted", 32'(bus.halted), 32'd0);
      chk("rst_scnt", 32'(bus.stall_cnt), 32'd0);

      // Back-to-back r7 read-after-write: stall counter must saturate.
      bus.d1_dst_en = 1'b1; bus.d1_dst = 4'd7;
      bus.d1_src0_en = 1'b1; bus.d1_src0 = 4'd7;
      repeat (500) tick();
      @(negedge clk);
      chk("sat_scnt", 32'(bus.stall_cnt), 32'(CMAX));
      clear_inputs();
      tick();

      // Randomised traffic against the model.
      for (int c = 0; c < 4000; c++) begin
         reset          = ($urandom_range(0, 999) < 8);
         bus.e_halt     = ($urandom_range(0, 999) < 5);
         bus.e_redirect = ($urandom_range(0, 99) < 8);
         bus.e_target   = 16'($urandom);
         bus.d1_src0_en = 1'($urandom_range(0, 1));
         bus.d1_src0    = 4'($urandom_range(0, 5));
         bus.d1_src1_en = 1'($urandom_range(0, 1));
         bus.d1_src1    = 4'($urandom_range(0, 5));
         bus.d1_dst_en  = 1'($urandom_range(0, 1));
         bus.d1_dst     = 4'($urandom_range(0, 5));
         tick();
      end
      reset = 1'b0;
      clear_inputs();
      repeat (3) tick();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
